zculling_stage: RTL and testbench

Streaming depth-test stage that sits directly downstream of the rasterization page in the 3D-rendering pipeline. It consumes the fragment stream produced by the rasterizer and tests each fragment against an on-chip Z-buffer. Fragments that are nearer than the stored depth are written back to the Z-buffer. For every triangle it emits a count header followed by the surviving pixels. The next page wrapper instantiates it behind its leaf interface, using the same 32-bit valid/ready stream ports.

---
 rtl/zculling_stage.sv | 176 +++++++++++++++++
 tb/tb_zculling_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/zculling_stage.sv
// zculling_stage: streaming depth test against an on-chip 8-bit Z-buffer.
// Per triangle: read a count header, test each fragment (strictly nearer wins),
// buffer the survivors, then emit a count header followed by the survivors.
module zculling_stage #(
  parameter int DIM_BITS  = 8,
  parameter int PIX_DEPTH = 512,
  parameter int CNT_BITS  = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [31:0] Input_1_V_TDATA,
  input  logic        Input_1_V_TVALID,
  output logic        Input_1_V_TREADY,
  output logic [31:0] Output_1_V_TDATA,
  output logic        Output_1_V_TVALID,
  input  logic        Output_1_V_TREADY,
  output logic        overflow,
  output logic        busy
);

  localparam int ZAW    = 2 * DIM_BITS;
  localparam int ZDEPTH = 1 << ZAW;
  localparam int MW     = $clog2(PIX_DEPTH + 1);
  localparam int PAW    = (PIX_DEPTH > 1) ? $clog2(PIX_DEPTH) : 1;
  localparam logic [MW-1:0] M_MAX = MW'(PIX_DEPTH);

  typedef enum logic [2:0] {
    S_CLEAR, S_FETCH_HDR, S_FETCH_FRAG, S_CMP, S_SEND_HDR, S_SEND_PIX
  } state_t;

  state_t r_state, w_next;

  logic [ZAW-1:0]      r_caddr;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_pend;
  logic [31:0]         r_frag;
  logic [7:0]          r_zrd;
  logic [MW-1:0]       r_m;
  logic [MW-1:0]       r_rd;
  logic                r_ovf;

  logic [7:0]  r_zbuf [0:ZDEPTH-1];
  logic [31:0] r_pix  [0:PIX_DEPTH-1];

  logic           w_in_hs, w_out_hs, w_pass, w_room, w_last_pix;
  logic [ZAW-1:0] w_in_addr, w_frag_addr, w_zwaddr;
  logic [7:0]     w_zwdata;
  logic           w_zwe, w_zre, w_push;

  assign w_in_hs     = Input_1_V_TVALID & Input_1_V_TREADY;
  assign w_out_hs    = Output_1_V_TVALID & Output_1_V_TREADY;
  assign w_in_addr   = {Input_1_V_TDATA[8 +: DIM_BITS], Input_1_V_TDATA[0 +: DIM_BITS]};
  assign w_frag_addr = {r_frag[8 +: DIM_BITS], r_frag[0 +: DIM_BITS]};
  // Equal depth fails so the first-drawn fragment keeps the pixel.
  assign w_pass      = r_frag[23:16] < r_zrd;
  assign w_room      = r_m < M_MAX;
  assign w_last_pix  = r_rd == (r_m - 1'b1);
  assign overflow    = r_ovf;

  // State register; reset always restarts the Z-buffer clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_CLEAR;
    else           r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: begin
        if (&r_caddr) begin
          if (!r_pend)           w_next = S_FETCH_HDR;
          else if (r_cnt == '0)  w_next = S_SEND_HDR;
          else                   w_next = S_FETCH_FRAG;
        end
      end
      S_FETCH_HDR: begin
        if (w_in_hs) begin
          if (Input_1_V_TDATA[31])                         w_next = S_CLEAR;
          else if (Input_1_V_TDATA[CNT_BITS-1:0] == '0)    w_next = S_SEND_HDR;
          else                                             w_next = S_FETCH_FRAG;
        end
      end
      S_FETCH_FRAG: if (w_in_hs) w_next = S_CMP;
      S_CMP:        w_next = (r_cnt == CNT_BITS'(1)) ? S_SEND_HDR : S_FETCH_FRAG;
      S_SEND_HDR: begin
        if (w_out_hs) w_next = (r_m != '0) ? S_SEND_PIX : S_FETCH_HDR;
      end
      S_SEND_PIX: if (w_out_hs && w_last_pix) w_next = S_FETCH_HDR;
      default:    w_next = S_CLEAR;
    endcase
  end

  // Outputs and RAM strobes decoded from the current state.
  always_comb begin
    Input_1_V_TREADY  = (r_state == S_FETCH_HDR) || (r_state == S_FETCH_FRAG);
    Output_1_V_TVALID = (r_state == S_SEND_HDR) || (r_state == S_SEND_PIX);
    busy              = (r_state != S_FETCH_HDR);
    Output_1_V_TDATA  = '0;
    w_zwe             = 1'b0;
    w_zwaddr          = r_caddr;
    w_zwdata          = 8'hFF;
    w_zre             = (r_state == S_FETCH_FRAG) && w_in_hs;
    w_push            = 1'b0;
    case (r_state)
      S_CLEAR:    w_zwe = 1'b1;
      S_CMP: begin
        if (w_pass) begin
          w_zwe    = 1'b1;
          w_zwaddr = w_frag_addr;
          w_zwdata = r_frag[23:16];
          w_push   = w_room;
        end
      end
      S_SEND_HDR: Output_1_V_TDATA = {{(32-CNT_BITS){1'b0}}, CNT_BITS'(r_m)};
      S_SEND_PIX: Output_1_V_TDATA = r_pix[r_rd[PAW-1:0]];
      default: ;
    endcase
  end

  // Control counters: clear address, remaining count, survivor count, read pointer, overflow.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_caddr <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_m     <= '0;
      r_rd    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_caddr <= r_caddr + 1'b1;
          if (&r_caddr) r_pend <= 1'b0;
        end
        S_FETCH_HDR: begin
          if (w_in_hs) begin
            r_cnt  <= Input_1_V_TDATA[CNT_BITS-1:0];
            r_pend <= Input_1_V_TDATA[31];
          end
        end
        S_CMP: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_pass) begin
            if (w_room) r_m   <= r_m + 1'b1;
            else        r_ovf <= 1'b1;
          end
        end
        S_SEND_PIX: begin
          if (w_out_hs) begin
            if (w_last_pix) begin
              r_m  <= '0;
              r_rd <= '0;
            end else begin
              r_rd <= r_rd + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Z-buffer: one write port, synchronous read issued on the fragment handshake.
  always_ff @(posedge ap_clk) begin
    if (w_zwe) r_zbuf[w_zwaddr] <= w_zwdata;
    if (w_zre) r_zrd <= r_zbuf[w_in_addr];
  end

  // Fragment latch and survivor buffer (data only, no reset).
  always_ff @(posedge ap_clk) begin
    if (w_zre)  r_frag <= Input_1_V_TDATA;
    if (w_push) r_pix[r_m[PAW-1:0]] <= r_frag;
  end

endmodule

// File: tb/tb_zculling_stage.sv
// Directed bench for zculling_stage with a reduced Z-buffer and a 4-entry pixel buffer.
module tb_zculling_stage;

  localparam int DIM_BITS  = 7;
  localparam int PIX_DEPTH = 4;
  localparam int CNT_BITS  = 16;
  localparam int CLR_CYC   = 1 << (2 * DIM_BITS);
  localparam int BOUND     = CLR_CYC + 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        ovf;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] expq [$];
  logic [31:0] fr [6];

  always #5 clk = ~clk;

  zculling_stage #(.DIM_BITS(DIM_BITS), .PIX_DEPTH(PIX_DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .ap_clk            (clk),
    .ap_rst_n          (rst_n),
    .Input_1_V_TDATA   (in_data),
    .Input_1_V_TVALID  (in_valid),
    .Input_1_V_TREADY  (in_ready),
    .Output_1_V_TDATA  (out_data),
    .Output_1_V_TVALID (out_valid),
    .Output_1_V_TREADY (out_ready),
    .overflow          (ovf),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  // Present one input word and hold it until the block takes it.
  task automatic send(input logic [31:0] w);
    int t;
    t = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_ready", {31'b0, in_ready}, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Take one output word, optionally with random backpressure; checks hold stability.
  task automatic recv(input bit bp, output logic [31:0] w);
    int t;
    bit got, hold;
    logic [31:0] held;
    t = 0; got = 1'b0; hold = 1'b0; held = '0; w = '0;
    @(negedge clk);
    while (t < BOUND) begin
      if (hold) chk("hold_data", out_data, held);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got = 1'b1;
        break;
      end
      hold = out_valid;
      held = out_data;
      @(negedge clk);
      t++;
    end
    if (!got) chk("recv_valid", {31'b0, out_valid}, 32'd1);
    else begin
      w = out_data;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  // Compare the output stream against expq, then confirm nothing extra follows.
  task automatic drain(input string tag, input bit bp);
    logic [31:0] e, w;
    int i;
    i = 0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      recv(bp, w);
      chk($sformatf("%s[%0d]", tag, i), w, e);
      i++;
    end
    chk($sformatf("%s_end_valid", tag), {31'b0, out_valid}, 32'd0);
  endtask

  // Count cycles from reset release until input is accepted.
  task automatic wait_clear(input string tag);
    int t;
    t = 0;
    while (!in_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("%s_cycles", tag), t, CLR_CYC);
    chk($sformatf("%s_busy", tag), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_tready", {31'b0, in_ready}, 32'd0);
    chk("rst_tvalid", {31'b0, out_valid}, 32'd0);
    chk("rst_tdata", out_data, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b1;
    wait_clear("clr0");

    // Two passing fragments at (2,3): 0x40 then 0x20.
    send(32'h0000_0002); send(32'h1140_0302); send(32'h2220_0302);
    expq = '{32'h0000_0002, 32'h1140_0302, 32'h2220_0302};
    drain("t2", 1'b0);

    // Equal (0x20) and farther (0x30) both fail.
    send(32'h0000_0002); send(32'h3320_0302); send(32'h4430_0302);
    expq = '{32'h0000_0000};
    drain("t3", 1'b0);

    // Clear first, then N=1 with z=0xFE passes.
    send(32'h8000_0001); send(32'h55FE_0504);
    expq = '{32'h0000_0001, 32'h55FE_0504};
    drain("t4a", 1'b0);
    // z=0xFF against cleared 0xFF fails.
    send(32'h0000_0001); send(32'h66FF_0706);
    expq = '{32'h0000_0000};
    drain("t4b", 1'b0);
    // (2,3) was cleared, so z=0x30 now passes there.
    send(32'h0000_0001); send(32'h7730_0302);
    expq = '{32'h0000_0001, 32'h7730_0302};
    drain("t4c", 1'b0);

    // N=0: header appears the cycle after the handshake.
    send(32'h0000_0000);
    chk("n0_latency", {31'b0, out_valid}, 32'd1);
    expq = '{32'h0000_0000};
    drain("t5", 1'b0);

    // Six passing fragments into a 4-deep buffer, drained with backpressure.
    chk("ovf_before", {31'b0, ovf}, 32'd0);
    send(32'h0000_0006);
    for (int i = 0; i < 6; i++) begin
      fr[i] = {8'hA0 + 8'(i), 8'h10, 8'h10, 8'h10 + 8'(i)};
      send(fr[i]);
    end
    expq = '{32'h0000_0004, fr[0], fr[1], fr[2], fr[3]};
    drain("t6", 1'b1);
    chk("ovf_after", {31'b0, ovf}, 32'd1);
    chk("t6_busy", {31'b0, busy}, 32'd0);

    // Reset while the result header is pending: everything is dropped.
    send(32'h0000_0002); send(32'h7710_3030); send(32'h7810_3131);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t7_pending", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_tvalid", {31'b0, out_valid}, 32'd0);
    chk("t7_rst_tdata", out_data, 32'd0);
    chk("t7_rst_ovf", {31'b0, ovf}, 32'd0);
    chk("t7_rst_busy", {31'b0, busy}, 32'd1);
    chk("t7_rst_tready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("clr1");
    send(32'h0000_0000);
    expq = '{32'h0000_0000};
    drain("t7", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
